// File: rtl/ahb_mtx_input_stage.sv
// Per-master input stage of the L1 AHB matrix.
// Holds a master's address phase while the target output port is busy,
// presents either the live or the held transfer to the decoder/arbiters,
// and generates the master-facing HREADYOUT/HRESP.
module ahb_mtx_input_stage #(
  parameter int ADDR_WIDTH    = 32,
  parameter bit RESP_ERR_PASS = 1'b1
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic [3:0]            HPROTS,
  input  logic                  HMASTLOCKS,
  input  logic                  HREADYS,
  output logic                  HREADYOUTS,
  output logic                  HRESPS,
  output logic                  sel_out,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [1:0]            trans_out,
  output logic                  write_out,
  output logic [2:0]            size_out,
  output logic [2:0]            burst_out,
  output logic [3:0]            prot_out,
  output logic                  lock_out,
  output logic                  req_out,
  input  logic                  addr_accept,
  input  logic                  data_ready,
  input  logic                  data_resp
);

  logic                  live_valid;
  logic                  capture;
  logic                  release_hold;
  logic                  accept_any;

  logic                  pend_reg, pend_next;
  logic                  dphase_reg, dphase_next;

  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [1:0]            trans_reg;
  logic                  write_reg;
  logic [2:0]            size_reg;
  logic [2:0]            burst_reg;
  logic [3:0]            prot_reg;
  logic                  lock_reg;

  // Only NONSEQ/SEQ with the bus ready are real transfers; IDLE/BUSY never request.
  assign live_valid   = HSELS & HREADYS & HTRANSS[1];
  // The hold register is frozen while pending, so a stray HREADYS cannot overwrite it.
  assign capture      = ~pend_reg & live_valid & ~addr_accept;
  assign release_hold = pend_reg & addr_accept;
  assign accept_any   = release_hold | (~pend_reg & live_valid & addr_accept);

  // Next-state: pending flag and data-phase flag
  always_comb begin
    pend_next   = pend_reg;
    dphase_next = dphase_reg;
    if (capture) begin
      pend_next = 1'b1;
    end else if (release_hold) begin
      pend_next = 1'b0;
    end
    // A new accept in the same cycle as data_ready keeps the data phase open.
    if (accept_any) begin
      dphase_next = 1'b1;
    end else if (data_ready) begin
      dphase_next = 1'b0;
    end
  end

  // State register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      pend_reg   <= 1'b0;
      dphase_reg <= 1'b0;
    end else begin
      pend_reg   <= pend_next;
      dphase_reg <= dphase_next;
    end
  end

  // Hold register: captures the address phase the output port could not take
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      addr_reg  <= '0;
      trans_reg <= '0;
      write_reg <= 1'b0;
      size_reg  <= '0;
      burst_reg <= '0;
      prot_reg  <= '0;
      lock_reg  <= 1'b0;
    end else if (capture) begin
      addr_reg  <= HADDRS;
      trans_reg <= HTRANSS;
      write_reg <= HWRITES;
      size_reg  <= HSIZES;
      burst_reg <= HBURSTS;
      prot_reg  <= HPROTS;
      lock_reg  <= HMASTLOCKS;
    end
  end

  // Output mux: held transfer while pending, otherwise live pass-through
  always_comb begin
    sel_out    = 1'b0;
    addr_out   = '0;
    trans_out  = 2'b00;
    write_out  = 1'b0;
    size_out   = '0;
    burst_out  = '0;
    prot_out   = '0;
    lock_out   = 1'b0;
    req_out    = 1'b0;
    HREADYOUTS = 1'b1;
    HRESPS     = 1'b0;
    // Reset forces the quiet state immediately, without waiting for a clock.
    if (!HRESET) begin
      if (pend_reg) begin
        sel_out   = 1'b1;
        addr_out  = addr_reg;
        trans_out = trans_reg;
        write_out = write_reg;
        size_out  = size_reg;
        burst_out = burst_reg;
        prot_out  = prot_reg;
        lock_out  = lock_reg;
        req_out   = 1'b1;
      end else begin
        sel_out   = HSELS & HREADYS;
        addr_out  = HADDRS;
        trans_out = HTRANSS;
        write_out = HWRITES;
        size_out  = HSIZES;
        burst_out = HBURSTS;
        prot_out  = HPROTS;
        lock_out  = HMASTLOCKS;
        req_out   = live_valid;
      end
      if (pend_reg) begin
        HREADYOUTS = 1'b0;
      end else if (dphase_reg) begin
        HREADYOUTS = data_ready;
      end
      HRESPS = dphase_reg & ~pend_reg & data_resp & RESP_ERR_PASS;
    end
  end

endmodule
